// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C master controller and i2c_target.
//   - I2C_ADDR_W      : width of a 7-bit I2C address
//   - i2c_state_e     : i2c_target protocol states
//   - i2c_cmd_e       : master command codes, shared by master and target benches
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_WAIT
  } i2c_state_e;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_WR      = 3'd1,
    CMD_RD      = 3'd2,
    CMD_STOP    = 3'd3,
    CMD_RESTART = 3'd4
  } i2c_cmd_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: SYNC_STAGES-flop synchronizer plus one history flop, giving
// a clean level and single-cycle rise/fall pulses for one bus line.
// Ports:
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   d_i          : raw (asynchronous) line value
//   q_o          : synchronized line level
//   rise_o       : one-cycle pulse on synchronized 0->1
//   fall_o       : one-cycle pulse on synchronized 1->0
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  q_o & ~hist_q;
  assign fall_o = ~q_o &  hist_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) endpoint with 7-bit address match, a write
// byte stream (rx) and a read byte handshake (tx). Open-drain: lines are only
// pulled low or released.
// Optional macro I2C_TARGET_CLK_STRETCH_EN: when a read byte starts with no tx
// byte buffered, hold SCL low until one arrives (otherwise 8'hFF is sent and
// SCL is never driven).
// Ports:
//   clk_i, rst_i    : system clock, asynchronous active-high reset
//   scl_io, sda_io  : open-drain I2C clock / data
//   tx_data_i/valid : byte offered for the next master read
//   tx_ready_o      : tx byte accepted this cycle when valid
//   rx_data_o       : last byte written by the master
//   rx_valid_o      : one-cycle pulse when rx_data_o updates
//   busy_o          : addressed transaction in progress
//   rw_o            : R/W bit of current transaction (1 = read)
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h42,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  inout  wire        scl_io,
  inout  wire        sda_io,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       rw_o
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(scl_io),
    .q_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sda_io),
    .q_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl_s;
  assign stop  = sda_rise & scl_s;

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       full_q, full_d;
  logic       tx_start;
  logic [7:0] byte_in;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic       scl_oe_q, scl_oe_d;
  logic       stall_q, stall_d;
  logic [2:0] rel_cnt_q, rel_cnt_d;
`endif

  assign byte_in = {sh_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_buf_d   = tx_buf_q;
    full_d     = full_q;
    tx_start   = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    scl_oe_d   = scl_oe_q;
    stall_d    = stall_q;
    rel_cnt_d  = rel_cnt_q;
`endif

    if (tx_valid_i && !full_q) begin
      tx_buf_d = tx_data_i;
      full_d   = 1'b1;
    end

    if (start || stop) begin
      state_d  = start ? ST_ADDR : ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      if (stop) busy_d = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_d  = 1'b0;
      stall_d   = 1'b0;
      rel_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (byte_in[7:1] == ADDR) begin
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        // ACK slot: first fall starts the pull-down, second fall ends it.
        ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_TX_DATA;
              tx_start = 1'b1;
            end else begin
              state_d = ST_RX_DATA;
            end
          end
        end
        ST_RX_DATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d      = '0;
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            state_d    = ST_RX_ACK;
          end
        end
        // cnt counts rises; a fall with cnt==0 starts a byte, cnt==8 ends it.
        ST_TX_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              tx_start = 1'b1;
            end else if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_TX_ACK;
            end else begin
              sh_d     = {sh_q[6:0], sh_q[7]};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        ST_TX_ACK: if (scl_rise) begin
          cnt_d   = '0;
          state_d = sda_s ? ST_WAIT : ST_TX_DATA;
        end
        default: ;
      endcase

      if (tx_start) begin
        if (full_q) begin
          sh_d     = tx_buf_q;
          full_d   = 1'b0;
          sda_oe_d = ~tx_buf_q[7];
        end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
          scl_oe_d = 1'b1;
          stall_d  = 1'b1;
          sda_oe_d = 1'b0;
`else
          sh_d     = '1;
          sda_oe_d = 1'b0;
`endif
        end
      end

`ifdef I2C_TARGET_CLK_STRETCH_EN
      // Bit 7 goes out with the load; SCL is let go a few cycles later so it
      // is settled before the master sees the rising edge.
      if (stall_q && full_q) begin
        sh_d      = tx_buf_q;
        full_d    = 1'b0;
        sda_oe_d  = ~tx_buf_q[7];
        stall_d   = 1'b0;
        rel_cnt_d = 3'd4;
      end else if (rel_cnt_q != 3'd0) begin
        rel_cnt_d = rel_cnt_q - 3'd1;
        if (rel_cnt_q == 3'd1) scl_oe_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_buf_q   <= '0;
      full_q     <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_q   <= 1'b0;
      stall_q    <= 1'b0;
      rel_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_buf_q   <= tx_buf_d;
      full_q     <= full_d;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_q   <= scl_oe_d;
      stall_q    <= stall_d;
      rel_cnt_q  <= rel_cnt_d;
`endif
    end
  end

  assign sda_io = sda_oe_q ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  assign scl_io = scl_oe_q ? 1'b0 : 1'bz;
`else
  assign scl_io = 1'bz;
`endif

  // Held low during reset so every output reads 0 while rst_i is asserted.
  assign tx_ready_o = ~full_q & ~rst_i;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign rw_o       = rw_q;

endmodule
